// File: rtl/forwarding_table_cam.sv
// forwarding_table_cam
//   Layer-2 forwarding table. Each forwarder interface sends a lookup request.
//   A round-robin arbiter admits one request per cycle into a two-stage
//   pipeline:
//     stage 1 - register the request
//     stage 2 - compare against every entry in parallel and register the response
//   Lookups that miss are queued for the controller in a small FWFT FIFO.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   req_valid/ready/dest/src    per-interface lookup requests
//                               (MACs packed 48 bits per interface)
//   resp_valid/port/drop        per-interface one-cycle lookup response
//   wr_*                        controller table write
//   rd_*                        controller table read (one-cycle latency)
//   miss_*                      miss queue to the controller
//                               (valid/ready, first-word-fall-through)
//   miss_overflow_cnt           saturating count of misses lost to a full queue
//
// Handshake rule: a transfer happens on every rising edge where valid and ready
// are both high. The design never makes ready depend on anything but valid and
// internal state.
module forwarding_table_cam #(
    parameter int NUM_INTERFACES = 3,
    parameter int NUM_ENTRIES    = 64,
    parameter int MISS_DEPTH     = 4,
    localparam int PW = ($clog2(NUM_INTERFACES) < 1) ? 1 : $clog2(NUM_INTERFACES),
    localparam int IW = $clog2(NUM_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_INTERFACES-1:0]    req_valid,
    output logic [NUM_INTERFACES-1:0]    req_ready,
    input  logic [48*NUM_INTERFACES-1:0] req_dest_mac,
    input  logic [48*NUM_INTERFACES-1:0] req_src_mac,
    output logic [NUM_INTERFACES-1:0]    resp_valid,
    output logic [PW*NUM_INTERFACES-1:0] resp_port,
    output logic [NUM_INTERFACES-1:0]    resp_drop,
    input  logic                         wr_valid,
    input  logic [IW-1:0]                wr_index,
    input  logic                         wr_entry_valid,
    input  logic [47:0]                  wr_mac,
    input  logic [PW-1:0]                wr_port,
    input  logic                         rd_valid,
    input  logic [IW-1:0]                rd_index,
    output logic                         rd_data_valid,
    output logic                         rd_entry_valid,
    output logic [47:0]                  rd_mac,
    output logic [PW-1:0]                rd_port,
    output logic                         miss_valid,
    input  logic                         miss_ready,
    output logic [PW-1:0]                miss_if,
    output logic [47:0]                  miss_dest_mac,
    output logic [47:0]                  miss_src_mac,
    output logic [15:0]                  miss_overflow_cnt
);
    localparam int AW = $clog2(MISS_DEPTH);

    // Unpack the per-interface MAC buses into arrays.
    logic [47:0] dest_arr [NUM_INTERFACES];
    logic [47:0] src_arr  [NUM_INTERFACES];
    logic [PW-1:0] resp_port_q [NUM_INTERFACES];
    for (genvar g = 0; g < NUM_INTERFACES; g++) begin : g_if
        assign dest_arr[g] = req_dest_mac[48*g +: 48];
        assign src_arr[g]  = req_src_mac[48*g +: 48];
        assign resp_port[PW*g +: PW] = resp_port_q[g];
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: search starts at rr_ptr and wraps around.
    // ------------------------------------------------------------------
    logic [PW-1:0] rr_ptr, grant_idx, cand_idx;
    logic          grant_any;
    int            cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_INTERFACES; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_INTERFACES) cand = cand - NUM_INTERFACES;
            cand_idx = PW'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Gated by rst so that no request is accepted while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (grant_any && rst) req_ready[grant_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Table storage. Only the valid bits are reset.
    // ------------------------------------------------------------------
    logic [NUM_ENTRIES-1:0] entry_valid;
    logic [47:0]            entry_mac  [NUM_ENTRIES];
    logic [PW-1:0]          entry_port [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_valid) begin
            entry_mac[wr_index]  <= wr_mac;
            entry_port[wr_index] <= wr_port;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 register and parallel compare
    // ------------------------------------------------------------------
    logic          s1_valid;
    logic [PW-1:0] s1_id;
    logic [47:0]   s1_dest, s1_src;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [PW-1:0] hit_port;
    logic          forward, push_req, push_ok, pop, fifo_full;

    // Scanning downwards leaves the lowest matching index in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entry_valid[i] && (entry_mac[i] == s1_dest)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign hit_port = entry_port[hit_idx];
    assign forward  = hit && (hit_port != s1_id);   // a hairpin hit is dropped silently
    assign push_req = s1_valid && !hit;

    // ------------------------------------------------------------------
    // Miss FIFO (FWFT). A push into a full FIFO still lands when a pop
    // frees a slot on the same edge.
    // ------------------------------------------------------------------
    logic [PW-1:0] fifo_id   [MISS_DEPTH];
    logic [47:0]   fifo_dest [MISS_DEPTH];
    logic [47:0]   fifo_src  [MISS_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign fifo_full     = (count == (AW+1)'(MISS_DEPTH));
    assign miss_valid    = (count != '0);
    assign pop           = miss_valid && miss_ready;
    assign push_ok       = push_req && (!fifo_full || pop);
    assign miss_if       = miss_valid ? fifo_id[rd_ptr]   : '0;
    assign miss_dest_mac = miss_valid ? fifo_dest[rd_ptr] : '0;
    assign miss_src_mac  = miss_valid ? fifo_src[rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_id[wr_ptr]   <= s1_id;
            fifo_dest[wr_ptr] <= s1_dest;
            fifo_src[wr_ptr]  <= s1_src;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr            <= '0;
            s1_valid          <= 1'b0;
            s1_id             <= '0;
            s1_dest           <= '0;
            s1_src            <= '0;
            resp_valid        <= '0;
            resp_drop         <= '0;
            for (int i = 0; i < NUM_INTERFACES; i++) resp_port_q[i] <= '0;
            entry_valid       <= '0;
            rd_data_valid     <= 1'b0;
            rd_entry_valid    <= 1'b0;
            rd_mac            <= '0;
            rd_port           <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            miss_overflow_cnt <= '0;
        end else begin
            // arbiter and stage 1
            if (grant_any) begin
                rr_ptr  <= (grant_idx == PW'(NUM_INTERFACES - 1)) ? '0 : grant_idx + 1'b1;
                s1_id   <= grant_idx;
                s1_dest <= dest_arr[grant_idx];
                s1_src  <= src_arr[grant_idx];
            end
            s1_valid <= grant_any;

            // stage 2: registered response
            resp_valid <= '0;
            resp_drop  <= '0;
            for (int i = 0; i < NUM_INTERFACES; i++) resp_port_q[i] <= '0;
            if (s1_valid) begin
                resp_valid[s1_id] <= 1'b1;
                if (forward) resp_port_q[s1_id] <= hit_port;
                else         resp_drop[s1_id]   <= 1'b1;
            end

            // table valid bits and read port (read returns pre-write contents)
            if (wr_valid) entry_valid[wr_index] <= wr_entry_valid;
            rd_data_valid <= rd_valid;
            if (rd_valid) begin
                rd_entry_valid <= entry_valid[rd_index];
                rd_mac         <= entry_mac[rd_index];
                rd_port        <= entry_port[rd_index];
            end

            // miss FIFO pointers and overflow counter
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push_req && !push_ok && (miss_overflow_cnt != 16'hFFFF))
                miss_overflow_cnt <= miss_overflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_forwarding_table_cam.sv
// Directed bench for forwarding_table_cam (default parameters: 3 interfaces,
// 64 entries, miss queue depth 4). Inputs change and outputs are sampled on
// the falling clock edge.
module tb_forwarding_table_cam;
    localparam int N  = 3;
    localparam int PW = 2;
    localparam int IW = 6;
    localparam int MD = 4;

    localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_B = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] MAC_U = 48'hAABB_CCDD_EEFF;
    localparam logic [47:0] MAC_2 = 48'h0200_0000_0002;
    localparam logic [47:0] MAC_3 = 48'h0300_0000_0003;
    localparam logic [47:0] SRC_X = 48'h5555_6666_7777;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_drop;
    logic [48*N-1:0] req_dest_mac, req_src_mac;
    logic [PW*N-1:0] resp_port;
    logic            wr_valid, wr_entry_valid, rd_valid, rd_data_valid, rd_entry_valid;
    logic [IW-1:0]   wr_index, rd_index;
    logic [47:0]     wr_mac, rd_mac, miss_dest_mac, miss_src_mac;
    logic [PW-1:0]   wr_port, rd_port, miss_if;
    logic            miss_valid, miss_ready;
    logic [15:0]     miss_overflow_cnt;

    forwarding_table_cam #(.NUM_INTERFACES(N), .NUM_ENTRIES(64), .MISS_DEPTH(MD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_mac(req_dest_mac), .req_src_mac(req_src_mac),
        .resp_valid(resp_valid), .resp_port(resp_port), .resp_drop(resp_drop),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_entry_valid(wr_entry_valid),
        .wr_mac(wr_mac), .wr_port(wr_port),
        .rd_valid(rd_valid), .rd_index(rd_index), .rd_data_valid(rd_data_valid),
        .rd_entry_valid(rd_entry_valid), .rd_mac(rd_mac), .rd_port(rd_port),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_if(miss_if),
        .miss_dest_mac(miss_dest_mac), .miss_src_mac(miss_src_mac),
        .miss_overflow_cnt(miss_overflow_cnt)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [47:0] exp_q[$];
    int          grant_q[$];
    int          g;
    logic [47:0] mac_k;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] one_hot(input int ifn);
        return N'(1) << ifn;
    endfunction

    function automatic logic [PW*N-1:0] port_vec(input int ifn, input logic [PW-1:0] p);
        return (PW*N)'(p) << (PW*ifn);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"},  64'(req_ready), 64'h0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
        check({tag, "_resp_port"},  64'(resp_port), 64'h0);
        check({tag, "_resp_drop"},  64'(resp_drop), 64'h0);
        check({tag, "_rd_dv"},      64'({rd_data_valid, rd_entry_valid, rd_port}), 64'h0);
        check({tag, "_rd_mac"},     64'(rd_mac), 64'h0);
        check({tag, "_miss_valid"}, 64'({miss_valid, miss_if}), 64'h0);
        check({tag, "_miss_dest"},  64'(miss_dest_mac), 64'h0);
        check({tag, "_miss_src"},   64'(miss_src_mac), 64'h0);
        check({tag, "_ovf"},        64'(miss_overflow_cnt), 64'h0);
    endtask

    // ---------------- drivers ----------------
    task automatic write_entry(input logic [IW-1:0] idx, input logic ev,
                               input logic [47:0] mac, input logic [PW-1:0] port);
        wr_valid = 1'b1; wr_index = idx; wr_entry_valid = ev; wr_mac = mac; wr_port = port;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_entry(input logic [IW-1:0] idx);
        rd_valid = 1'b1; rd_index = idx;
        @(negedge clk);
        rd_valid = 1'b0;
    endtask

    // Single-requester lookup; the response is checked two edges after the request.
    task automatic lookup(input string tag, input int ifn, input logic [47:0] dmac,
                          input logic pop, input logic [PW-1:0] exp_port, input logic exp_drop);
        req_valid    = one_hot(ifn);
        req_dest_mac = (48*N)'(dmac) << (48*ifn);
        req_src_mac  = (48*N)'(SRC_X) << (48*ifn);
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(one_hot(ifn)));
        @(negedge clk);
        req_valid  = '0;
        miss_ready = pop;
        @(negedge clk);
        miss_ready = 1'b0;
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'(one_hot(ifn)));
        check({tag, "_resp_port"},  64'(resp_port),  64'(port_vec(ifn, exp_port)));
        check({tag, "_resp_drop"},  64'(resp_drop),  exp_drop ? 64'(one_hot(ifn)) : 64'h0);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        req_valid = '1; req_dest_mac = '0; req_src_mac = '0;
        wr_valid = 1'b0; wr_index = '0; wr_entry_valid = 1'b0; wr_mac = '0; wr_port = '0;
        rd_valid = 1'b0; rd_index = '0; miss_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check_outputs_zero("reset");
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);

        // basic forwarding hit
        write_entry(6'd5, 1'b1, MAC_A, 2'd2);
        lookup("hit_if0", 0, MAC_A, 1'b0, 2'd2, 1'b0);
        check("hit_no_miss", 64'(miss_valid), 64'h0);

        // read port, then read and write of the same index in one cycle
        read_entry(6'd5);
        check("rd_dv",   64'(rd_data_valid), 64'h1);
        check("rd_ev",   64'(rd_entry_valid), 64'h1);
        check("rd_mac",  64'(rd_mac), 64'(MAC_A));
        check("rd_port", 64'(rd_port), 64'h2);
        rd_valid = 1'b1; rd_index = 6'd5;
        write_entry(6'd5, 1'b1, MAC_B, 2'd1);
        rd_valid = 1'b0;
        check("rdw_old_mac",  64'(rd_mac), 64'(MAC_A));
        check("rdw_old_port", 64'(rd_port), 64'h2);
        read_entry(6'd5);
        check("rd_new_mac",  64'(rd_mac), 64'(MAC_B));
        check("rd_new_port", 64'(rd_port), 64'h1);
        check("rd_dv_idle",  64'(rd_data_valid), 64'h1);
        @(negedge clk);
        check("rd_dv_drop",  64'(rd_data_valid), 64'h0);
        write_entry(6'd5, 1'b1, MAC_A, 2'd2);

        // unknown MAC from if1 goes to the miss queue
        lookup("miss_if1", 1, MAC_U, 1'b0, 2'd0, 1'b1);
        check("miss_valid", 64'(miss_valid), 64'h1);
        check("miss_if",    64'(miss_if), 64'h1);
        check("miss_dest",  64'(miss_dest_mac), 64'(MAC_U));
        check("miss_src",   64'(miss_src_mac), 64'(SRC_X));
        miss_ready = 1'b1;
        @(negedge clk);
        miss_ready = 1'b0;
        check("miss_popped", 64'(miss_valid), 64'h0);

        // duplicate MAC: lowest index wins until it is invalidated
        write_entry(6'd3, 1'b1, MAC_2, 2'd1);
        write_entry(6'd9, 1'b1, MAC_2, 2'd2);
        lookup("dup_low", 0, MAC_2, 1'b0, 2'd1, 1'b0);
        write_entry(6'd3, 1'b0, MAC_2, 2'd1);
        lookup("dup_inval", 0, MAC_2, 1'b0, 2'd2, 1'b0);

        // hairpin hits: dropped, nothing queued
        write_entry(6'd7, 1'b1, MAC_3, 2'd0);
        lookup("hairpin0", 0, MAC_3, 1'b0, 2'd0, 1'b1);
        check("hairpin0_nomiss", 64'(miss_valid), 64'h0);
        lookup("hairpin2", 2, MAC_A, 1'b0, 2'd0, 1'b1);
        check("hairpin2_nomiss", 64'(miss_valid), 64'h0);

        // all interfaces request continuously; pointer starts at 0 here
        req_valid    = '1;
        req_dest_mac = {N{MAC_A}};
        for (int k = 0; k < 8; k++) begin
            if (k == 6) req_valid = '0;
            #1;
            if (k < 6) begin
                check("rr_grant", 64'(req_ready), 64'(one_hot(k % 3)));
                grant_q.push_back(k % 3);
            end
            if (k >= 2) begin
                g = grant_q.pop_front();
                check("rr_resp_valid", 64'(resp_valid), 64'(one_hot(g)));
                check("rr_resp_port",  64'(resp_port), (g == 2) ? 64'h0 : 64'(port_vec(g, 2'd2)));
                check("rr_resp_drop",  64'(resp_drop), (g == 2) ? 64'(one_hot(2)) : 64'h0);
            end
            @(negedge clk);
        end
        check("rr_nomiss", 64'(miss_valid), 64'h0);

        // miss queue overflow with the controller stalled
        for (int k = 0; k < MD + 3; k++) begin
            mac_k = 48'hDEAD_0000_0000 + 48'(k);
            lookup("ovf", 0, mac_k, 1'b0, 2'd0, 1'b1);
            if (k < MD) exp_q.push_back(mac_k);
        end
        check("ovf_cnt", 64'(miss_overflow_cnt), 64'h3);
        check("ovf_full_valid", 64'(miss_valid), 64'h1);
        // push into a full queue while it pops: the push is kept
        mac_k = 48'hDEAD_0000_0077;
        lookup("ovf_poppush", 0, mac_k, 1'b1, 2'd0, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(mac_k);
        check("ovf_cnt_kept", 64'(miss_overflow_cnt), 64'h3);
        for (int k = 0; k < MD; k++) begin
            check("drain_valid", 64'(miss_valid), 64'h1);
            check("drain_dest",  64'(miss_dest_mac), 64'(exp_q.pop_front()));
            check("drain_if",    64'(miss_if), 64'h0);
            miss_ready = 1'b1;
            @(negedge clk);
            miss_ready = 1'b0;
        end
        check("drain_empty", 64'(miss_valid), 64'h0);

        // reset in the middle of traffic
        lookup("pre_rst_miss", 1, MAC_U, 1'b0, 2'd0, 1'b1);
        req_valid = one_hot(0); req_dest_mac = (48*N)'(MAC_A);
        @(negedge clk);
        req_valid = '1;
        #2 rst = 1'b0;
        #1 check_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        check("post_rst_resp0", 64'(resp_valid), 64'h0);
        @(negedge clk);
        check("post_rst_resp1", 64'(resp_valid), 64'h0);
        check("post_rst_nomiss", 64'(miss_valid), 64'h0);
        read_entry(6'd5);
        check("post_rst_rd_ev", 64'(rd_entry_valid), 64'h0);
        lookup("post_rst_a", 0, MAC_A, 1'b0, 2'd0, 1'b1);
        check("post_rst_miss", 64'(miss_valid), 64'h1);
        check("post_rst_miss_dest", 64'(miss_dest_mac), 64'(MAC_A));
        lookup("post_rst_2", 1, MAC_2, 1'b0, 2'd0, 1'b1);

        summary();
    end
endmodule
